// File: rtl/sprite_pkg.sv
// rtl/sprite_pkg.sv - shared sprite constants, colour type and round-robin pick helper
// Contents: SPR_W_DEF/SPR_H_DEF sprite bounds, COLOR_W/COLOR_BLACK colour constants,
//           color_t, rr_pick(req, ptr, n) -> one-hot winner (up to 8 requesters).
package sprite_pkg;

    localparam int unsigned SPR_W_DEF   = 584;
    localparam int unsigned SPR_H_DEF   = 26;
    localparam int unsigned COLOR_W     = 12;
    localparam logic [11:0] COLOR_BLACK = 12'h000;

    typedef logic [11:0] color_t;

    // First asserted bit searching ptr, ptr+1, ... modulo n. Bits at or above n are ignored.
    function automatic logic [7:0] rr_pick(input logic [7:0] req, input logic [2:0] ptr,
                                           input int unsigned n);
        logic [7:0]  g;
        int unsigned idx;
        g = '0;
        for (int unsigned k = 0; k < 8; k++) begin
            if (k < n) begin
                idx = (32'(ptr) + k) % n;
                if (g == '0 && req[idx[2:0]]) begin
                    g[idx[2:0]] = 1'b1;
                end
            end
        end
        return g;
    endfunction

endpackage

// File: rtl/sprite_rom_arbiter_if.sv
// rtl/sprite_rom_arbiter_if.sv - requester/ROM/response bus of the sprite ROM arbiter
// Signals: en, req, req_row, req_col, gnt (requester side); rom_row, rom_col, rom_data (ROM);
//          rsp_valid, rsp_id, rsp_data (tagged colour return).
// Modports: master = requesters + ROM, slave = arbiter.
interface sprite_rom_arbiter_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ROW_W   = 8,
    parameter int unsigned COL_W   = 10,
    parameter int unsigned DATA_W  = 12
);
    localparam int unsigned ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic                     en;
    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*ROW_W-1:0] req_row;
    logic [NUM_REQ*COL_W-1:0] req_col;
    logic [NUM_REQ-1:0]       gnt;
    logic [ROW_W-1:0]         rom_row;
    logic [COL_W-1:0]         rom_col;
    logic [DATA_W-1:0]        rom_data;
    logic                     rsp_valid;
    logic [ID_W-1:0]          rsp_id;
    logic [DATA_W-1:0]        rsp_data;

    modport master (
        output en, req, req_row, req_col, rom_data,
        input  gnt, rom_row, rom_col, rsp_valid, rsp_id, rsp_data
    );

    modport slave (
        input  en, req, req_row, req_col, rom_data,
        output gnt, rom_row, rom_col, rsp_valid, rsp_id, rsp_data
    );

endinterface

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational one-hot arbiter with registered round-robin pointer
// Ports: clk, rst_n (sync active-low), i_req [N] (already masked), o_gnt [N] one-hot.
// Build option SPRITE_ARB_FIXED_PRIO_EN: lowest index always wins, pointer register removed.
module rr_arbiter
    import sprite_pkg::*;
#(
    parameter int unsigned N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] i_req,
    output logic [N-1:0] o_gnt
);

    logic [7:0] w_req8;
    logic [7:0] w_pick8;
    logic [2:0] w_ptr;
    logic [2:0] w_idx;
    logic       w_any;

    always_comb begin
        w_req8        = '0;
        w_req8[N-1:0] = i_req;
    end

`ifdef SPRITE_ARB_FIXED_PRIO_EN
    assign w_ptr = 3'd0;
`else
    logic [2:0] r_ptr;

    assign w_ptr = r_ptr;

    // Pointer moves just past the winner so the winner becomes lowest priority next cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ptr <= 3'd0;
        end else if (w_any) begin
            r_ptr <= (32'(w_idx) == N - 1) ? 3'd0 : w_idx + 3'd1;
        end
    end
`endif

    assign w_pick8 = rr_pick(w_req8, w_ptr, N);
    assign w_any   = |w_pick8;
    assign o_gnt   = w_pick8[N-1:0];

    always_comb begin
        w_idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (w_pick8[i]) begin
                w_idx = 3'(i);
            end
        end
    end

endmodule

// File: rtl/sprite_rom_arbiter.sv
// rtl/sprite_rom_arbiter.sv - shares one 1-cycle sprite ROM between NUM_REQ requesters
// Ports: clk, rst_n (sync active-low), bus (sprite_rom_arbiter_if.slave):
//   en/req/req_row/req_col in, gnt out (combinational), rom_row/rom_col out (registered),
//   rom_data in, rsp_valid/rsp_id/rsp_data out two cycles after the grant.
// Build option SPRITE_ARB_FIXED_PRIO_EN selects fixed priority inside rr_arbiter.
module sprite_rom_arbiter
    import sprite_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ROW_W   = 8,
    parameter int unsigned COL_W   = 10,
    parameter int unsigned DATA_W  = COLOR_W,
    parameter int unsigned SPR_W   = SPR_W_DEF,
    parameter int unsigned SPR_H   = SPR_H_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    sprite_rom_arbiter_if.slave   bus
);

    localparam int unsigned ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0] w_req_masked;
    logic [NUM_REQ-1:0] w_gnt;
    logic               w_any;
    logic [ID_W-1:0]    w_id;
    logic [ROW_W-1:0]   w_row;
    logic [COL_W-1:0]   w_col;
    logic               w_oob;

    logic [ROW_W-1:0]   r_rom_row;
    logic [COL_W-1:0]   r_rom_col;
    logic               r_s1_valid;
    logic [ID_W-1:0]    r_s1_id;
    logic               r_s1_oob;
    logic               r_s2_valid;
    logic [ID_W-1:0]    r_s2_id;
    logic               r_s2_oob;

    // Folding rst_n into the mask keeps gnt low during reset without a separate gate.
    assign w_req_masked = bus.req & {NUM_REQ{bus.en & rst_n}};

    rr_arbiter #(.N(NUM_REQ)) u_rr_arbiter (
        .clk   (clk),
        .rst_n (rst_n),
        .i_req (w_req_masked),
        .o_gnt (w_gnt)
    );

    assign bus.gnt = w_gnt;
    assign w_any   = |w_gnt;

    always_comb begin
        w_id  = '0;
        w_row = '0;
        w_col = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_gnt[i]) begin
                w_id  = ID_W'(i);
                w_row = bus.req_row[i*ROW_W +: ROW_W];
                w_col = bus.req_col[i*COL_W +: COL_W];
            end
        end
    end

    // Column is checked on its own so an over-wide col cannot alias into the next row.
    assign w_oob = (32'(w_row) >= SPR_H) || (32'(w_col) >= SPR_W);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rom_row  <= '0;
            r_rom_col  <= '0;
            r_s1_valid <= 1'b0;
            r_s1_id    <= '0;
            r_s1_oob   <= 1'b0;
            r_s2_valid <= 1'b0;
            r_s2_id    <= '0;
            r_s2_oob   <= 1'b0;
        end else begin
            r_s1_valid <= w_any;
            if (w_any) begin
                r_rom_row <= w_row;
                r_rom_col <= w_col;
                r_s1_id   <= w_id;
                r_s1_oob  <= w_oob;
            end
            // Stage 2 lines up with the ROM's internal read register.
            r_s2_valid <= r_s1_valid;
            r_s2_id    <= r_s1_id;
            r_s2_oob   <= r_s1_oob;
        end
    end

    assign bus.rom_row   = r_rom_row;
    assign bus.rom_col   = r_rom_col;
    assign bus.rsp_valid = r_s2_valid;
    assign bus.rsp_id    = r_s2_id;
    assign bus.rsp_data  = (r_s2_valid && !r_s2_oob) ? bus.rom_data : DATA_W'(COLOR_BLACK);

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// tb/tb_sprite_rom_arbiter.sv - scoreboard bench for sprite_rom_arbiter with a behavioural ROM
module tb_sprite_rom_arbiter;
    import sprite_pkg::*;

    localparam int NR = 4;
    localparam int SW = 584;
    localparam int SH = 26;

    typedef struct {
        int          due;
        int          id;
        logic [11:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   ptr_m  = 0;
    exp_t sbq[$];

    always #5 clk = ~clk;

    sprite_rom_arbiter_if #(.NUM_REQ(NR), .ROW_W(8), .COL_W(10), .DATA_W(12)) bus ();

    sprite_rom_arbiter #(
        .NUM_REQ (NR),
        .ROW_W   (8),
        .COL_W   (10),
        .DATA_W  (12),
        .SPR_W   (SW),
        .SPR_H   (SH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    function automatic logic [11:0] rom_fn(input int addr);
        if (addr == 634) return 12'h000;
        if (addr >= 640 && addr < 650) return 12'hFFF;
        return 12'(addr * 7) | 12'h001;
    endfunction

    function automatic logic [11:0] exp_data(input int row, input int col);
        if (row >= SH || col >= SW) return 12'h000;
        return rom_fn(row * SW + col);
    endfunction

    // Single-port ROM with a one-cycle registered read.
    always @(posedge clk) begin
        bus.rom_data <= rom_fn(int'(bus.rom_row) * SW + int'(bus.rom_col));
        cyc <= cyc + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_slot(input int i, input int row, input int col);
        bus.req_row[i*8 +: 8]  = 8'(row);
        bus.req_col[i*10 +: 10] = 10'(col);
    endtask

    // Per-cycle model: response check against the queue, then grant prediction.
    always @(negedge clk) begin
        exp_t        e;
        logic        exp_v;
        int          win;
        int          idx;
        logic [3:0]  egnt;

        exp_v = (sbq.size() > 0) && (sbq[0].due == cyc);
        chk("rsp_valid", 32'(bus.rsp_valid), 32'(exp_v));
        if (exp_v) begin
            e = sbq.pop_front();
            chk("rsp_id", 32'(bus.rsp_id), 32'(e.id));
            chk("rsp_data", 32'(bus.rsp_data), 32'(e.data));
        end else begin
            chk("rsp_data_idle", 32'(bus.rsp_data), 32'd0);
        end

        if (rst_n === 1'b1) begin
            win = -1;
            for (int k = 0; k < NR; k++) begin
                idx = (ptr_m + k) % NR;
                if (win < 0 && bus.en && bus.req[idx]) win = idx;
            end
            egnt = (win >= 0) ? 4'(1 << win) : 4'd0;
            chk("gnt", 32'(bus.gnt), 32'(egnt));
            if (win >= 0) begin
                e.due  = cyc + 2;
                e.id   = win;
                e.data = exp_data(int'(bus.req_row[win*8 +: 8]), int'(bus.req_col[win*10 +: 10]));
                sbq.push_back(e);
`ifndef SPRITE_ARB_FIXED_PRIO_EN
                ptr_m = (win + 1) % NR;
`endif
            end
        end else begin
            chk("gnt_in_reset", 32'(bus.gnt), 32'd0);
            sbq.delete();
            ptr_m = 0;
        end
    end

    initial begin
        rst_n       = 1'b0;
        bus.en      = 1'b1;
        bus.req     = 4'b0001;
        bus.req_row = '0;
        bus.req_col = '0;
        set_slot(0, 1, 60);
        step(2);
        chk("reset_rom_row", 32'(bus.rom_row), 32'd0);
        chk("reset_rom_col", 32'(bus.rom_col), 32'd0);
        chk("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("reset_rsp_id", 32'(bus.rsp_id), 32'd0);

        // single requester, white pixel at addr 644
        rst_n = 1'b1;
        step(1);
        bus.req = 4'b0000;
        step(3);

        // colour-0 pixel at addr 634 from requester 2
        set_slot(2, 1, 50);
        bus.req = 4'b0100;
        step(1);
        bus.req = 4'b0000;
        step(3);

        // bounds: col past edge, row past edge, col == SPR_W, last row, last col
        set_slot(1, 0, 600);
        bus.req = 4'b0010;
        step(1);
        set_slot(1, 30, 10);
        step(1);
        set_slot(0, 0, 584);
        bus.req = 4'b0001;
        step(1);
        set_slot(2, 25, 0);
        bus.req = 4'b0100;
        step(1);
        set_slot(3, 2, 583);
        bus.req = 4'b1000;
        step(1);
        bus.req = 4'b0000;
        step(3);

        // all four held: strict rotation
        for (int i = 0; i < NR; i++) set_slot(i, i + 2, i * 10 + 5);
        bus.req = 4'b1111;
        step(8);
        bus.req = 4'b0000;
        step(3);

        // enable dropped after two grants, then resumed
        bus.req = 4'b1111;
        step(2);
        bus.en = 1'b0;
        step(3);
        bus.en = 1'b1;
        step(2);
        bus.req = 4'b0000;
        step(3);

        // reset with two reads in flight
        bus.req = 4'b1111;
        step(2);
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        step(2);
        bus.req = 4'b0000;
        step(4);

        chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
